line_buf_ctrl: RTL

- Address and strobe sequencer that drives the three-line-RAM buffer (RAM A/B/C) in the CCD edge-detection path.
- Counts incoming pixel columns and rows. Writes each line round-robin into one RAM while reading the two older lines at the same column.
- Emits window-valid and line-select qualifiers so the 3x3 edge kernel can identify rows n-1 and n-2 on the RAM outputs.

---
 rtl/line_buf_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/line_buf_ctrl.sv
// Address/strobe sequencer for the three-line RAM buffer of the CCD edge path.
// Optional protocol error counter enabled by defining LBC_ERR_CNT_EN.
module line_buf_ctrl #(
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int RD_LAT       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       rama_wren,
  output logic       ramb_wren,
  output logic       ramc_wren,
  output logic       rama_rden,
  output logic       ramb_rden,
  output logic       ramc_rden,
  output logic [9:0] rama_wradd,
  output logic [9:0] ramb_wradd,
  output logic [9:0] ramc_wradd,
  output logic [9:0] rama_rdadd,
  output logic [9:0] ramb_rdadd,
  output logic [9:0] ramc_rdadd,
  output logic       win_valid,
  output logic [9:0] win_col,
  output logic [1:0] win_sel,
  output logic       frame_done,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, FILL0, FILL1, RUN} state_t;

  localparam logic [9:0]  COL_LAST = 10'(LINE_WIDTH - 1);
  localparam logic [11:0] ROW_LAST = 12'(FRAME_HEIGHT - 1);

  state_t      state, state_nxt, state_e;
  logic [9:0]  col, col_nxt, col_e;
  logic [11:0] row, row_nxt, row_e;
  logic [1:0]  sel, sel_nxt, sel_e;
  logic        accept, restart, line_end, frame_end;
  logic [2:0]  wren_d, rden_d, wren_q, rden_q;
  logic [9:0]  wradd_q [3];
  logic [9:0]  rdadd_q [3];
  logic [9:0]  rd_col_q;
  logic [1:0]  rd_sel_q;
  logic        frame_done_q;
  logic        win_v_pipe [RD_LAT];
  logic [9:0]  win_c_pipe [RD_LAT];
  logic [1:0]  win_s_pipe [RD_LAT];

  // A start-of-frame pixel overrides the current position and is itself column 0.
  assign restart   = in_valid && in_sof;
  assign accept    = in_valid && (in_sof || state != IDLE);
  assign state_e   = restart ? FILL0 : state;
  assign col_e     = restart ? '0 : col;
  assign row_e     = restart ? '0 : row;
  assign sel_e     = restart ? '0 : sel;
  assign line_end  = (col_e == COL_LAST);
  assign frame_end = line_end && (row_e == ROW_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      sel   <= sel_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    sel_nxt   = sel;
    if (accept) begin
      if (frame_end) begin
        state_nxt = IDLE;
        col_nxt   = '0;
        row_nxt   = '0;
        sel_nxt   = '0;
      end else if (line_end) begin
        col_nxt   = '0;
        row_nxt   = row_e + 12'd1;
        sel_nxt   = (sel_e == 2'd2) ? 2'd0 : sel_e + 2'd1;
        state_nxt = (state_e == FILL0) ? FILL1 : RUN;
      end else begin
        state_nxt = state_e;
        col_nxt   = col_e + 10'd1;
        row_nxt   = row_e;
        sel_nxt   = sel_e;
      end
    end
  end

  always_comb begin
    wren_d = '0;
    rden_d = '0;
    if (accept) begin
      wren_d = 3'b001 << sel_e;
      if (state_e == RUN) rden_d = ~wren_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wren_q       <= '0;
      rden_q       <= '0;
      frame_done_q <= 1'b0;
      rd_col_q     <= '0;
      rd_sel_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        wradd_q[i] <= '0;
        rdadd_q[i] <= '0;
      end
    end else begin
      wren_q       <= wren_d;
      rden_q       <= rden_d;
      frame_done_q <= accept && frame_end;
      if (|rden_d) begin
        rd_col_q <= col_e;
        rd_sel_q <= sel_e;
      end
      for (int i = 0; i < 3; i++) begin
        if (wren_d[i]) wradd_q[i] <= col_e;
        if (rden_d[i]) rdadd_q[i] <= col_e;
      end
    end
  end

  // NOTE: the window delay line is a handful of flops, so it is reset like any other state; win_valid must drop with rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        win_v_pipe[i] <= 1'b0;
        win_c_pipe[i] <= '0;
        win_s_pipe[i] <= '0;
      end
    end else begin
      win_v_pipe[0] <= |rden_q;
      win_c_pipe[0] <= rd_col_q;
      win_s_pipe[0] <= rd_sel_q;
      for (int i = 1; i < RD_LAT; i++) begin
        win_v_pipe[i] <= win_v_pipe[i-1];
        win_c_pipe[i] <= win_c_pipe[i-1];
        win_s_pipe[i] <= win_s_pipe[i-1];
      end
    end
  end

`ifdef LBC_ERR_CNT_EN
  logic [7:0] err_q;

  // Short frame and short line on the same sof pixel count as one error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (restart && (state != IDLE || col != '0) && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

  assign {ramc_wren, ramb_wren, rama_wren} = wren_q;
  assign {ramc_rden, ramb_rden, rama_rden} = rden_q;
  assign rama_wradd = wradd_q[0];
  assign ramb_wradd = wradd_q[1];
  assign ramc_wradd = wradd_q[2];
  assign rama_rdadd = rdadd_q[0];
  assign ramb_rdadd = rdadd_q[1];
  assign ramc_rdadd = rdadd_q[2];
  assign frame_done = frame_done_q;
  assign win_valid  = win_v_pipe[RD_LAT-1];
  assign win_col    = win_c_pipe[RD_LAT-1];
  assign win_sel    = win_s_pipe[RD_LAT-1];

endmodule
